// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// the captured-request record and the alignment rule.
package mem_access_unit_pkg;

  localparam int REQ_TYPE_W = 3;

  // req_type[1:0] size field; 2'b11 is illegal
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Fields of the accepted request needed after IDLE
  typedef struct packed {
    logic       we;
    logic       uns;
    logic [1:0] size;
    logic [1:0] off;
  } reqCap_t;

  // Illegal size, odd halfword, or word not on a 4-byte boundary
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) | ((size == SIZE_H) & off[0]) | ((size == SIZE_W) & (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store data replication plus lane mask,
// and load lane extraction with sign or zero extension.
module lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  stSize,
  input  logic [1:0]  stOff,
  input  logic [31:0] stData,
  output logic [31:0] stWdata,
  output logic [3:0]  stMask,
  input  logic [1:0]  ldSize,
  input  logic [1:0]  ldOff,
  input  logic        ldUns,
  input  logic [31:0] ldRaw,
  output logic [31:0] ldData
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  // Store side: replicate the right-aligned data across lanes and enable the addressed lanes
  always_comb begin
    stWdata = stData;
    stMask  = 4'b1111;
    case (stSize)
      SIZE_B: begin
        stWdata = {4{stData[7:0]}};
        stMask  = 4'b0001 << stOff;
      end
      SIZE_H: begin
        stWdata = {2{stData[15:0]}};
        stMask  = stOff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane(s), then extend to 32 bits
  always_comb begin
    ldByte = ldRaw[7:0];
    case (ldOff)
      2'd1:    ldByte = ldRaw[15:8];
      2'd2:    ldByte = ldRaw[23:16];
      2'd3:    ldByte = ldRaw[31:24];
      default: ldByte = ldRaw[7:0];
    endcase
    ldHalf = ldOff[1] ? ldRaw[31:16] : ldRaw[15:0];
    case (ldSize)
      SIZE_B:  ldData = {{24{~ldUns & ldByte[7]}}, ldByte};
      SIZE_H:  ldData = {{16{~ldUns & ldHalf[15]}}, ldHalf};
      default: ldData = ldRaw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the MEM stage and the data bus.
// IDLE accepts an aligned request, ISSUE fires one strobe, WAIT follows the
// slave busy line (with a timeout for stuck devices), DONE presents the result
// for one cycle while the pipeline advances.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 13,
  parameter int TIMEOUT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_we,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [REQ_TYPE_W-1:0]      req_type,
  output logic                       stall,
  output logic [31:0]                resp_data,
  output logic                       misalign,
  output logic                       bus_err,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_mask,
  input  logic [31:0]                mem_rdata,
  output logic                       mem_rstrb,
  output logic                       mem_wstrb,
  input  logic                       mem_rbusy,
  input  logic                       mem_wbusy
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                 state;
  reqCap_t                    cap;
  logic [DATA_ADDR_WIDTH-1:0] addrQ;
  logic [31:0]                wdataQ;
  logic [3:0]                 maskQ;
  logic [31:0]                respQ;
  logic                       timeoutQ;
  logic [TIMEOUT_WIDTH-1:0]   waitCnt;
  logic [TIMEOUT_WIDTH-1:0]   waitNxt;
  logic                       bad;
  logic                       busy;
  logic [31:0]                stWdata;
  logic [3:0]                 stMask;
  logic [31:0]                ldData;
  logic                       unusedReqAddr;

  // Only the low address bits reach the bus; the rest are ignored by design
  assign unusedReqAddr = ^req_addr;

  assign bad     = isMisaligned(req_type[1:0], req_addr[1:0]);
  assign busy    = cap.we ? mem_wbusy : mem_rbusy;
  assign waitNxt = waitCnt + CNT_ONE;

  lane_align uAlign (
    .stSize  (req_type[1:0]),
    .stOff   (req_addr[1:0]),
    .stData  (req_wdata),
    .stWdata (stWdata),
    .stMask  (stMask),
    .ldSize  (cap.size),
    .ldOff   (cap.off),
    .ldUns   (cap.uns),
    .ldRaw   (mem_rdata),
    .ldData  (ldData)
  );

  // Hold the pipeline from acceptance until DONE; forced low while reset is asserted
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:         stall = req_valid & ~bad;
        S_ISSUE,
        S_WAIT:         stall = 1'b1;
        default:        stall = 1'b0;
      endcase
    end
  end

  assign misalign  = ~rst & (state == S_IDLE) & req_valid & bad;
  assign mem_rstrb = (state == S_ISSUE) & ~cap.we;
  assign mem_wstrb = (state == S_ISSUE) & cap.we;
  assign bus_err   = (state == S_DONE) & timeoutQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign mem_mask  = maskQ;
  assign resp_data = respQ;

  // FSM, request capture, wait counter and load-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cap      <= '0;
      addrQ    <= '0;
      wdataQ   <= '0;
      maskQ    <= '0;
      respQ    <= '0;
      timeoutQ <= 1'b0;
      waitCnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && !bad) begin
            cap      <= '{we: req_we, uns: req_type[2], size: req_type[1:0], off: req_addr[1:0]};
            addrQ    <= req_addr[DATA_ADDR_WIDTH-1:0];
            wdataQ   <= stWdata;
            maskQ    <= stMask;
            timeoutQ <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          waitCnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!busy) begin
            if (!cap.we) respQ <= ldData;
            state <= S_DONE;
          end else if (waitNxt == CNT_MAX) begin
            // Slave never answered: give up with zero data and an error pulse
            respQ    <= '0;
            timeoutQ <= 1'b1;
            state    <= S_DONE;
          end else begin
            waitCnt <= waitNxt;
          end
        end
        default: begin
          // DONE: the request is still on the inputs this cycle, so go straight to IDLE
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single accesses plus
// hand-written reset-during-access sequences. A small bus slave model holds
// busy for a configurable number of cycles after each strobe.
module tb_mem_access_unit;

  localparam int DAW = 13;
  localparam int TW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_we;
  logic [31:0]    req_addr, req_wdata;
  logic [2:0]     req_type;
  logic           stall, misalign, bus_err;
  logic [31:0]    resp_data, mem_wdata, mem_rdata;
  logic [DAW-1:0] mem_addr;
  logic [3:0]     mem_mask;
  logic           mem_rstrb, mem_wstrb, mem_rbusy, mem_wbusy;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_ADDR_WIDTH(DAW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_type(req_type),
    .stall(stall), .resp_data(resp_data), .misalign(misalign), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  // Slave model: busy for busyCfg cycles after a strobe, on the matching line only
  int   busyCfg  = 0;
  int   busyLeft = 0;
  logic busyIsW  = 1'b0;
  always @(posedge clk) begin
    if (mem_rstrb || mem_wstrb) begin
      busyLeft <= busyCfg;
      busyIsW  <= mem_wstrb;
    end else if (busyLeft > 0) begin
      busyLeft <= busyLeft - 1;
    end
  end
  assign mem_wbusy = (busyLeft != 0) &  busyIsW;
  assign mem_rbusy = (busyLeft != 0) & ~busyIsW;

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
    logic [31:0] rdata;
    int          busy;
    bit          expMis;
    int          expStall;
    bit          chkResp;
    logic [31:0] expResp;
    logic [3:0]  expMask;
    logic [31:0] expWdata;
    bit          expErr;
  } vec_t;

  vec_t vecs[$];
  int   nCmp = 0;
  int   nBad = 0;

  function automatic vec_t mk(string nm, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [2:0] typ, logic [31:0] rdata, int busy, bit mis,
                              int st, bit cr, logic [31:0] er, logic [3:0] em,
                              logic [31:0] ew, bit ee);
    vec_t v;
    v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ; v.rdata = rdata;
    v.busy = busy; v.expMis = mis; v.expStall = st; v.chkResp = cr; v.expResp = er;
    v.expMask = em; v.expWdata = ew; v.expErr = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, exp);
    end
  endtask

  task automatic runAccess(input vec_t v);
    int stallCyc, rCyc, wCyc, errCyc, misCyc;
    bit done;
    logic [31:0] resp;
    stallCyc = 0; rCyc = 0; wCyc = 0; errCyc = 0; misCyc = 0; done = 1'b0; resp = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_type = v.typ; mem_rdata = v.rdata; busyCfg = v.busy;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      stallCyc += int'(stall); rCyc += int'(mem_rstrb); wCyc += int'(mem_wstrb);
      errCyc += int'(bus_err); misCyc += int'(misalign);
      if (!stall) begin
        done = 1'b1;
        if (c > 0) resp = resp_data;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      nCmp++; nBad++;
      $display("FAIL %s.complete: stall never released within 64 cycles", v.name);
    end
    @(negedge clk);
    req_valid = 1'b0;
    // Trailing window: nothing may be re-accepted or pulse again
    for (int c = 0; c < 3; c++) begin
      #1;
      stallCyc += int'(stall); rCyc += int'(mem_rstrb); wCyc += int'(mem_wstrb);
      errCyc += int'(bus_err); misCyc += int'(misalign);
      @(negedge clk);
    end
    chk({v.name, ".stall"},    32'(stallCyc), 32'(v.expStall));
    chk({v.name, ".misalign"}, 32'(misCyc),   32'(v.expMis));
    chk({v.name, ".rstrb"},    32'(rCyc),     32'(!v.expMis && !v.we));
    chk({v.name, ".wstrb"},    32'(wCyc),     32'(!v.expMis && v.we));
    chk({v.name, ".bus_err"},  32'(errCyc),   32'(v.expErr));
    if (v.chkResp) chk({v.name, ".resp"}, resp, v.expResp);
    if (!v.expMis) begin
      chk({v.name, ".addr"}, 32'(mem_addr), v.addr & 32'h1FFF);
      chk({v.name, ".mask"}, 32'(mem_mask), 32'(v.expMask));
      if (v.we) chk({v.name, ".wdata"}, mem_wdata, v.expWdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, we, addr, wdata, type, rdata, busy, mis, stall, chkResp, resp, mask, wdata, err
    vecs.push_back(mk("sw104",   1, 32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 32'h0,         0, 0,  3, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("lb103",   0, 32'h0000_0103, 32'h0,         3'b000, 32'h80FF_FF7F, 0, 0,  3, 1, 32'hFFFF_FF80, 4'b1000, 32'h0,         0));
    vecs.push_back(mk("lbu103",  0, 32'h0000_0103, 32'h0,         3'b100, 32'h80FF_FF7F, 0, 0,  3, 1, 32'h0000_0080, 4'b1000, 32'h0,         0));
    vecs.push_back(mk("sh202",   1, 32'h0000_0202, 32'h0000_1234, 3'b001, 32'h0,         5, 0,  8, 0, 32'h0,         4'b1100, 32'h1234_1234, 0));
    vecs.push_back(mk("lw101",   0, 32'h0000_0101, 32'h0,         3'b010, 32'h0,         0, 1,  0, 0, 32'h0,         4'b0000, 32'h0,         0));
    vecs.push_back(mk("sz11",    0, 32'h0000_0100, 32'h0,         3'b011, 32'h0,         0, 1,  0, 0, 32'h0,         4'b0000, 32'h0,         0));
    vecs.push_back(mk("lh103",   0, 32'h0000_0103, 32'h0,         3'b001, 32'h0,         0, 1,  0, 0, 32'h0,         4'b0000, 32'h0,         0));
    vecs.push_back(mk("lh102",   0, 32'h0000_0102, 32'h0,         3'b001, 32'h8001_0000, 2, 0,  5, 1, 32'hFFFF_8001, 4'b1100, 32'h0,         0));
    vecs.push_back(mk("lhu100",  0, 32'h0000_0100, 32'h0,         3'b101, 32'h1234_F00D, 0, 0,  3, 1, 32'h0000_F00D, 4'b0011, 32'h0,         0));
    vecs.push_back(mk("lb102",   0, 32'h0000_0102, 32'h0,         3'b000, 32'h0055_0000, 0, 0,  3, 1, 32'h0000_0055, 4'b0100, 32'h0,         0));
    vecs.push_back(mk("sb001",   1, 32'h0000_0001, 32'h0000_00A5, 3'b000, 32'h0,         0, 0,  3, 0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 0));
    vecs.push_back(mk("lw108",   0, 32'h0000_0108, 32'h0,         3'b010, 32'hCAFE_F00D, 1, 0,  4, 1, 32'hCAFE_F00D, 4'b1111, 32'h0,         0));
    vecs.push_back(mk("lwTmo",   0, 32'h0000_010C, 32'h0,         3'b010, 32'h1111_1111, 1000, 0, 17, 1, 32'h0,      4'b1111, 32'h0,         1));
    vecs.push_back(mk("lw110",   0, 32'h0000_0110, 32'h0,         3'b010, 32'h1122_3344, 0, 0,  3, 1, 32'h1122_3344, 4'b1111, 32'h0,         0));
    vecs.push_back(mk("sb113",   1, 32'h0000_0113, 32'h0000_007E, 3'b000, 32'hFFFF_FFFF, 0, 0,  3, 1, 32'h1122_3344, 4'b1000, 32'h7E7E_7E7E, 0));
    vecs.push_back(mk("swHiA",   1, 32'h0001_2340, 32'h0BAD_F00D, 3'b010, 32'h0,         0, 0,  3, 0, 32'h0,         4'b1111, 32'h0BAD_F00D, 0));

    // Reset state, with a legal request already on the inputs
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100;
    req_wdata = 32'h0; req_type = 3'b010; mem_rdata = 32'h0;
    #2;
    chk("rst.stall",     32'(stall),     32'h0);
    chk("rst.resp",      resp_data,      32'h0);
    chk("rst.bus_err",   32'(bus_err),   32'h0);
    chk("rst.mem_addr",  32'(mem_addr),  32'h0);
    chk("rst.mem_wdata", mem_wdata,      32'h0);
    chk("rst.mem_mask",  32'(mem_mask),  32'h0);
    chk("rst.rstrb",     32'(mem_rstrb), 32'h0);
    chk("rst.wstrb",     32'(mem_wstrb), 32'h0);
    req_addr = 32'h0000_0101;
    #1;
    chk("rst.misalign",  32'(misalign),  32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) runAccess(vecs[i]);

    // Reset while the write strobe is high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0200; req_type = 3'b010;
    req_wdata = 32'h55AA_55AA; busyCfg = 1000;
    @(negedge clk); #1;
    chk("rstIssue.wstrbPre", 32'(mem_wstrb), 32'h1);
    rst = 1'b1; #1;
    chk("rstIssue.wstrb", 32'(mem_wstrb), 32'h0);
    chk("rstIssue.stall", 32'(stall),     32'h0);
    chk("rstIssue.mask",  32'(mem_mask),  32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;

    // Reset during WAIT on a stuck read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0300; req_type = 3'b010; busyCfg = 1000;
    repeat (4) @(negedge clk);
    #1;
    chk("rstWait.stallPre", 32'(stall), 32'h1);
    rst = 1'b1; #1;
    chk("rstWait.stall",   32'(stall),     32'h0);
    chk("rstWait.rstrb",   32'(mem_rstrb), 32'h0);
    chk("rstWait.bus_err", 32'(bus_err),   32'h0);
    chk("rstWait.resp",    resp_data,      32'h0);
    chk("rstWait.addr",    32'(mem_addr),  32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;

    // Normal access after the reset
    runAccess(mk("lwAfterRst", 0, 32'h0000_0104, 32'h0, 3'b010, 32'hA5A5_0F0F, 0, 0, 3, 1,
                 32'hA5A5_0F0F, 4'b1111, 32'h0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
